// File: rtl/dtc_vote_accum.sv
// Majority-vote accumulator: counts classifier results over a window, then scans for the winning class.
// Optional early window end via input flush when DTC_VOTE_FLUSH_EN is defined.
module dtc_vote_accum #(
    parameter int WINDOW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_class,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef DTC_VOTE_FLUSH_EN
    input  logic       flush,
`endif
    output logic [2:0] outp,
    output logic [7:0] out_votes
);

    localparam logic [7:0] WIN = 8'(WINDOW);

    typedef enum logic [1:0] {ACCUM, DECIDE, PRESENT} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt [8];
    logic [7:0] n;
    logic [2:0] idx;
    logic [2:0] best_class;
    logic [7:0] best_count;
    logic       accept;
    logic [7:0] n_after;
    logic       end_window;

    assign accept  = in_valid && (state == ACCUM);
    assign n_after = n + {7'd0, accept};

    // A flushed window still counts a coincident sample, but an empty window never ends.
`ifdef DTC_VOTE_FLUSH_EN
    assign end_window = (n_after == WIN) || (flush && (n_after != 8'd0));
`else
    assign end_window = (n_after == WIN);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (end_window) state_nx = DECIDE;
            DECIDE:  if (idx == 3'd7) state_nx = PRESENT;
            PRESENT: if (out_ready) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    // Strict greater-than during the scan keeps ties on the lowest class index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) cnt[i] <= 8'd0;
            n          <= 8'd0;
            idx        <= 3'd0;
            best_class <= 3'd0;
            best_count <= 8'd0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) cnt[in_class] <= cnt[in_class] + 8'd1;
                    n <= n_after;
                end
                DECIDE: begin
                    if (cnt[idx] > best_count) begin
                        best_class <= idx;
                        best_count <= cnt[idx];
                    end
                    idx <= idx + 3'd1;
                end
                PRESENT: begin
                    if (out_ready) begin
                        for (int i = 0; i < 8; i++) cnt[i] <= 8'd0;
                        n          <= 8'd0;
                        idx        <= 3'd0;
                        best_class <= 3'd0;
                        best_count <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rst || (state == ACCUM);
    assign out_valid = !rst && (state == PRESENT);
    assign outp      = rst ? 3'd0 : best_class;
    assign out_votes = rst ? 8'd0 : best_count;

endmodule

// File: doc/dtc_vote_accum.md
DTC_VOTE_ACCUM -- requirements
Module: dtc_vote_accum

Interface
REQ-001 SHALL have parameter WINDOW, default 16, giving the number of accepted class samples per vote window; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the upstream classifier result is valid.
REQ-005 SHALL have port in_class, input, 3, the upstream classifier result (class 0..7).
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-007 SHALL have port out_valid, output, 1, meaning a vote result is presented.
REQ-008 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-009 SHALL have port outp, output, 3, the winning class.
REQ-010 SHALL have port out_votes, output, 8, the vote count of the winning class.

Function
REQ-011 SHALL implement a three-state FSM: ACCUM, DECIDE and PRESENT.
REQ-012 SHALL drive in_ready=1 only in ACCUM; a sample is accepted when in_valid and in_ready are both 1.
REQ-013 SHALL, on each accepted sample, increment the 8-bit counter cnt[in_class] and the sample counter n.
REQ-014 SHALL transition ACCUM->DECIDE in the cycle after the accept that makes n==WINDOW, with no further samples accepted.
REQ-015 SHALL, in DECIDE, scan the classes sequentially at one class per cycle over indices 0..7 (8 cycles), updating the best class/count only when cnt[i] > best_count strictly.
REQ-016 SHALL, as a consequence of REQ-015, resolve ties to the lowest class index.
REQ-017 SHALL give an all-zero count the best class 0 and best count 0.
REQ-018 SHALL transition DECIDE->PRESENT after index 7 is evaluated; latency: last accept at cycle T gives out_valid=1 at cycle T+9.
REQ-019 SHALL, in PRESENT, hold out_valid=1 and keep outp and out_votes stable until out_ready=1.
REQ-020 SHALL, on the out_valid&&out_ready cycle, clear all cnt[], n and best, and return to ACCUM; in_ready=1 the following cycle.
REQ-021 SHALL have no counter wrap: cnt[i] <= n <= WINDOW <= 255.
REQ-022 SHALL ignore in_class when no sample is accepted (in_valid=0 or in_ready=0).

Reset
REQ-023 SHALL, with rst=1 at a clock edge, enter ACCUM and clear cnt[], n, the scan index and best, with priority over every other event including an in-flight DECIDE or PRESENT.
REQ-024 SHALL drive the following output values during reset and in the cycle after it: in_ready=1, out_valid=0, outp=3'b000, out_votes=8'd0.

Configuration
REQ-025 SHALL, when macro DTC_VOTE_FLUSH_EN is defined, add input port flush (1 bit); flush=1 in ACCUM with n>=1 after that cycle's accept ends the window (ACCUM->DECIDE).
REQ-026 SHALL, when flush and an accept coincide, count the sample before ending the window.
REQ-027 SHALL ignore flush when n==0 after the accept, and in DECIDE and PRESENT.
REQ-028 SHALL, without DTC_VOTE_FLUSH_EN, have no flush port; windows end only at n==WINDOW.

Verification
REQ-029 SHALL cover: WINDOW=16, 16 samples of class 5 back-to-back, out_ready=1 -> out_valid at last-accept+9, outp=5, out_votes=16, in_ready=1 on the next cycle.
REQ-030 SHALL cover: classes 2 and 6 with 8 votes each -> outp=2, out_votes=8 (tie goes to the lower index).
REQ-031 SHALL cover: result presented, out_ready held 0 for 5 cycles with in_valid=1 -> outp and out_votes stable, in_ready=0, no samples counted.
REQ-032 SHALL cover: rst asserted during DECIDE after 16 samples -> next cycle out_valid=0, in_ready=1; a fresh window of 16 class-1 samples -> outp=1, out_votes=16.
REQ-033 SHALL cover, with DTC_VOTE_FLUSH_EN defined: 3 samples (7,7,4), flush coincident with the third -> outp=7, out_votes=2.
REQ-034 SHALL cover, with DTC_VOTE_FLUSH_EN defined: flush with n==0 -> stays in ACCUM.
